// File: rtl/reg_file_read_unit.sv
// Register file with bypassed combinational read ports and a valid/ready
// debug dump engine that streams every register out in index order.
module reg_file_read_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  dumpStart,
  input  logic                  dumpReady,
  output logic                  dumpValid,
  output logic [ADDR_WIDTH-1:0] dumpIndex,
  output logic [DATA_WIDTH-1:0] dumpData,
  output logic                  dumpBusy,
  output logic                  dumpDone
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] index_next;
  logic [ADDR_WIDTH-1:0] index_succ;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  valid_next;
  logic                  busy_next;

  // Value a reader sees this cycle, forwarding a write that commits on the next edge.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if (addr == '0) return '0;
    if (regWrite && (writeReg == addr)) return writeData;
    return regs[addr];
  endfunction

  assign readData1 = read_port(readReg1);
  assign readData2 = read_port(readReg2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (regWrite && (writeReg != '0)) begin
      regs[writeReg] <= writeData;
    end
  end

  always_comb begin
    state_next = state;
    index_next = dumpIndex;
    data_next  = dumpData;
    valid_next = dumpValid;
    busy_next  = dumpBusy;
    index_succ = dumpIndex + 1'b1;
    case (state)
      IDLE: begin
        if (dumpStart) begin
          state_next = SEND;
          index_next = '0;
          data_next  = '0;
          valid_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
      SEND: begin
        if (dumpValid && dumpReady) begin
          if (dumpIndex == LAST_INDEX) begin
            state_next = DONE;
            valid_next = 1'b0;
            busy_next  = 1'b0;
          end else begin
            index_next = index_succ;
            data_next  = read_port(index_succ);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dumpIndex <= '0;
      dumpData  <= '0;
      dumpValid <= 1'b0;
      dumpBusy  <= 1'b0;
    end else begin
      state     <= state_next;
      dumpIndex <= index_next;
      dumpData  <= data_next;
      dumpValid <= valid_next;
      dumpBusy  <= busy_next;
    end
  end

  assign dumpDone = (state == DONE);

endmodule

// File: tb/tb_reg_file_read_unit.sv
// Bench for reg_file_read_unit: vector table, random traffic against an array
// model, and dump sequences (free-flowing, stalled with writes, reset abort).
module tb_reg_file_read_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] readReg1;
  logic [AW-1:0] readReg2;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;
  logic          dumpStart;
  logic          dumpReady;
  logic          dumpValid;
  logic [AW-1:0] dumpIndex;
  logic [DW-1:0] dumpData;
  logic          dumpBusy;
  logic          dumpDone;

  reg_file_read_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .dumpStart(dumpStart),
    .dumpReady(dumpReady), .dumpValid(dumpValid), .dumpIndex(dumpIndex),
    .dumpData(dumpData), .dumpBusy(dumpBusy), .dumpDone(dumpDone)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  logic [DW-1:0] model [NR];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (regWrite && writeReg == a) return writeData;
    return model[a];
  endfunction

  // Advance one clock and commit the same edge's effect to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (regWrite && writeReg != 0) begin
      model[writeReg] = writeData;
    end
    #1;
  endtask

  task automatic check_all_zero(input string name);
    regWrite = 1'b0;
    for (int i = 0; i < NR; i++) begin
      readReg1 = AW'(i);
      readReg2 = AW'(NR - 1 - i);
      #1;
      check(name, readData1, '0);
      check(name, readData2, '0);
    end
  endtask

  // mode 0: ready always high; mode 1: ready toggles with writes while stalled;
  // mode 2: reset asserted while index 7 is presented.
  task automatic run_dump(input int mode);
    int            exp_idx;
    int            beats;
    int            busy_cnt;
    int            done_cnt;
    int            post;
    logic [DW-1:0] exp_data;
    bit            finished;
    bit            rdy;
    exp_idx = 0; beats = 0; busy_cnt = 0; done_cnt = 0; post = 0;
    exp_data = '0; finished = 0;
    regWrite = 1'b0; dumpReady = 1'b0; dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (dumpBusy) busy_cnt++;
      if (dumpDone) done_cnt++;
      if (post == 2) begin
        check("done_fall", dumpDone, 0);
        check("valid_idle", dumpValid, 0);
        finished = 1;
      end else if (post == 1) begin
        check("done_pulse", dumpDone, 1);
        check("valid_after", dumpValid, 0);
        check("busy_after", dumpBusy, 0);
        dumpReady = 1'b0;
        tick();
        post = 2;
      end else if (mode == 2 && exp_idx == 7) begin
        check("abort_index_seen", dumpIndex, 7);
        reset = 1'b1; regWrite = 1'b0; dumpReady = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", dumpValid, 0);
        check("abort_busy", dumpBusy, 0);
        check("abort_done", dumpDone, 0);
        check("abort_index", dumpIndex, 0);
        check("abort_data", dumpData, 0);
        dumpReady = 1'b0;
        tick();
        check("abort_no_done", dumpDone, 0);
        check_all_zero("abort_regs");
        finished = 1;
      end else begin
        check("dump_valid", dumpValid, 1);
        check("dump_busy", dumpBusy, 1);
        check("dump_index", dumpIndex, exp_idx[AW-1:0]);
        check("dump_data", dumpData, exp_data);
        if (mode == 0) check("dump_preload", dumpData, exp_idx);
        if (mode == 1 && exp_idx == 10) check("beat10", dumpData, 32'h0000A5A5);
        rdy = (mode == 1) ? (cyc % 2 == 1) : 1'b1;
        dumpReady = rdy;
        regWrite = 1'b0;
        dumpStart = (mode == 0 && cyc == 5);
        if (mode == 1 && exp_idx == 3 && !rdy) begin
          regWrite = 1'b1; writeReg = 10; writeData = 32'h0000A5A5;
        end
        if (mode == 1 && exp_idx == 4 && !rdy) begin
          regWrite = 1'b1; writeReg = 4; writeData = 32'h0000BBBB;
        end
        readReg1 = AW'(cyc % NR);
        readReg2 = exp_idx[AW-1:0];
        #1;
        check("dump_read1", readData1, model_read(readReg1));
        check("dump_read2", readData2, model_read(readReg2));
        tick();
        dumpStart = 1'b0;
        if (rdy) begin
          beats++;
          if (exp_idx == NR - 1) post = 1;
          else begin
            exp_idx++;
            exp_data = model[exp_idx];
          end
        end
      end
    end
    if (!finished) begin
      tests++; failed++;
      $display("FAIL dump_timeout: got no completion expected completion (mode %0d)", mode);
    end
    if (mode == 2) begin
      check("abort_beats", beats, 7);
      check("abort_done_cnt", done_cnt, 0);
    end else begin
      check("dump_beats", beats, NR);
      check("dump_done_cnt", done_cnt, 1);
      check("dump_busy_cnt", busy_cnt, (mode == 0) ? NR : 2 * NR);
    end
    regWrite = 1'b0; dumpReady = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd31, 32'h11111111, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 5'd7,  32'h0,        5'd5,  5'd31, 32'h11111111, 32'hFFFFFFFF};

    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0; dumpStart = 1'b0; dumpReady = 1'b0;
    tick();
    tick();
    check("rst_valid", dumpValid, 0);
    check("rst_index", dumpIndex, 0);
    check("rst_data", dumpData, 0);
    check("rst_busy", dumpBusy, 0);
    check("rst_done", dumpDone, 0);
    reset = 1'b0;
    check_all_zero("rst_regs");

    for (int i = 0; i < 7; i++) begin
      regWrite = vecs[i].we; writeReg = vecs[i].wa; writeData = vecs[i].wd;
      readReg1 = vecs[i].r1; readReg2 = vecs[i].r2;
      #1;
      check("vec_read1", readData1, vecs[i].e1);
      check("vec_read2", readData2, vecs[i].e2);
      tick();
    end

    for (int i = 0; i < 300; i++) begin
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = AW'($urandom_range(0, NR - 1));
      writeData = $urandom;
      readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : AW'($urandom_range(0, NR - 1));
      readReg2  = AW'($urandom_range(0, NR - 1));
      #1;
      check("rand_read1", readData1, model_read(readReg1));
      check("rand_read2", readData2, model_read(readReg2));
      tick();
    end
    regWrite = 1'b0;
    check("rand_dump_idle", dumpValid, 0);

    for (int i = 1; i < NR; i++) begin
      regWrite = 1'b1; writeReg = AW'(i); writeData = DW'(i);
      tick();
    end
    regWrite = 1'b0;

    run_dump(0);
    run_dump(1);
    run_dump(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
